// File: rtl/steer_pkg.sv
// Shared types, widths and phase helpers for the steering quadrature sequencer.
package steer_pkg;

   localparam int unsigned PERIOD_W = 16;
   localparam int unsigned RAMP_W   = PERIOD_W + 1;
   localparam int unsigned POS_W    = 8;

   localparam logic signed [POS_W-1:0] POS_MAX = 8'sh7f;
   localparam logic signed [POS_W-1:0] POS_MIN = 8'sh80;

   typedef enum logic [1:0] {IDLE, ACCEL, CRUISE, RETURN} steer_state_e;

   // One Gray step toward "right": 00 -> 01 -> 11 -> 10 -> 00
   function automatic logic [1:0] gray_next(input logic [1:0] ph);
      logic [1:0] r;
      case (ph)
         2'b00:   r = 2'b01;
         2'b01:   r = 2'b11;
         2'b11:   r = 2'b10;
         default: r = 2'b00;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] gray_prev(input logic [1:0] ph);
      logic [1:0] r;
      case (ph)
         2'b00:   r = 2'b10;
         2'b10:   r = 2'b11;
         2'b11:   r = 2'b01;
         default: r = 2'b00;
      endcase
      return r;
   endfunction

   // Saturating +/-1 on the signed wheel position
   function automatic logic signed [POS_W-1:0] pos_step(input logic signed [POS_W-1:0] pos,
                                                         input logic up);
      logic signed [POS_W-1:0] r;
      r = pos;
      if (up && (pos != POS_MAX))
         r = pos + POS_W'(1);
      else if (!up && (pos != POS_MIN))
         r = pos - POS_W'(1);
      return r;
   endfunction

endpackage

// File: rtl/steer_quad_ctrl_if.sv
// Request/phase bundle of one steering channel; the controller takes the slave side.
interface steer_quad_ctrl_if;
   import steer_pkg::*;

   logic                ce;
   logic                left;
   logic                right;
   logic [1:0]          steer;
   logic                moving;
   logic                dir;
   logic [PERIOD_W-1:0] period;

   modport master (output ce, left, right, input steer, moving, dir, period);
   modport slave  (input ce, left, right, output steer, moving, dir, period);

endinterface

// File: rtl/steer_rate_ramp.sv
// Step-period generator: reload period, ce-gated down-counter, saturating ramp, step strobe.
module steer_rate_ramp
   import steer_pkg::*;
#(
   parameter int unsigned CLKDIV_MAX = 22500,
   parameter int unsigned CLKDIV_MIN = 5625,
   parameter int unsigned RAMP_STEP  = 1875
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ce,
   input  logic                run,
   input  logic                load_max,
   input  logic                load_min,
   output logic                step_c,
   output logic                at_min_c,
   output logic [PERIOD_W-1:0] period
);

   localparam logic [PERIOD_W-1:0] P_MAX  = PERIOD_W'(CLKDIV_MAX);
   localparam logic [PERIOD_W-1:0] P_MIN  = PERIOD_W'(CLKDIV_MIN);
   localparam logic [PERIOD_W-1:0] P_ONE  = PERIOD_W'(1);
   localparam logic [RAMP_W-1:0]   R_STEP = RAMP_W'(RAMP_STEP);
   localparam logic [RAMP_W-1:0]   R_MIN  = RAMP_W'(CLKDIV_MIN);

   logic [PERIOD_W-1:0] count;
   logic [RAMP_W-1:0]   diff_c;
   logic [PERIOD_W-1:0] next_period_c;

   // Extra top bit flags underflow so the ramp floor cannot be skipped by wrap-around
   always_comb begin
      diff_c        = {1'b0, period} - R_STEP;
      next_period_c = P_MIN;
      if (!diff_c[RAMP_W-1] && (diff_c > R_MIN))
         next_period_c = diff_c[PERIOD_W-1:0];
   end

   assign step_c   = run & ce & (count == '0);
   assign at_min_c = (next_period_c == P_MIN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period <= P_MAX;
         count  <= P_MAX - P_ONE;
      end else if (load_max) begin
         period <= P_MAX;
         count  <= P_MAX - P_ONE;
      end else if (load_min) begin
         period <= P_MIN;
         count  <= P_MIN - P_ONE;
      end else if (step_c) begin
         period <= next_period_c;
         count  <= next_period_c - P_ONE;
      end else if (run && ce) begin
         count  <= count - P_ONE;
      end
   end

endmodule

// File: rtl/steer_quad_ctrl.sv
// Steering sequencer: left/right requests to accelerating Gray quadrature steps.
// Optional STEER_AUTOCENTER_EN adds a position counter and a RETURN-to-centre state.
module steer_quad_ctrl
   import steer_pkg::*;
#(
   parameter int unsigned CLKDIV_MAX = 22500,
   parameter int unsigned CLKDIV_MIN = 5625,
   parameter int unsigned RAMP_STEP  = 1875
) (
   input logic              CLK,
   input logic              reset,
   steer_quad_ctrl_if.slave bus
);

   steer_state_e        state, state_nxt;
   logic                left_q, right_q;
   logic [1:0]          steer_q;
   logic                dir_q, dir_nxt, moving_q;
   logic                req_c, req_dir_c, run_c;
   logic                load_max_c, load_min_c, do_step_c;
   logic                step_c, at_min_c;
   logic [PERIOD_W-1:0] period_w;
`ifdef STEER_AUTOCENTER_EN
   logic signed [POS_W-1:0] pos_q, pos_nxt;
`endif

   // Simultaneous left and right cancel out
   assign req_c     = left_q ^ right_q;
   assign req_dir_c = right_q;
   assign run_c     = (state != IDLE);

   steer_rate_ramp #(
      .CLKDIV_MAX(CLKDIV_MAX),
      .CLKDIV_MIN(CLKDIV_MIN),
      .RAMP_STEP (RAMP_STEP)
   ) u_ramp (
      .clk     (CLK),
      .rst     (reset),
      .ce      (bus.ce),
      .run     (run_c),
      .load_max(load_max_c),
      .load_min(load_min_c),
      .step_c  (step_c),
      .at_min_c(at_min_c),
      .period  (period_w)
   );

   always_comb begin
      state_nxt  = state;
      dir_nxt    = dir_q;
      load_max_c = 1'b0;
      load_min_c = 1'b0;
      do_step_c  = 1'b0;
`ifdef STEER_AUTOCENTER_EN
      pos_nxt    = pos_q;
`endif
      case (state)
         IDLE: begin
            if (req_c) begin
               state_nxt  = ACCEL;
               load_max_c = 1'b1;
               dir_nxt    = req_dir_c;
            end
         end
         ACCEL, CRUISE: begin
            // Reversal restarts the ramp and swallows any step due this cycle
            if (req_c && (req_dir_c != dir_q)) begin
               state_nxt  = ACCEL;
               load_max_c = 1'b1;
               dir_nxt    = req_dir_c;
            end else begin
               do_step_c = step_c;
`ifdef STEER_AUTOCENTER_EN
               if (step_c)
                  pos_nxt = pos_step(pos_q, dir_q);
`endif
               if (!req_c) begin
`ifdef STEER_AUTOCENTER_EN
                  if (pos_nxt != '0) begin
                     state_nxt  = RETURN;
                     load_min_c = 1'b1;
                     dir_nxt    = pos_nxt[POS_W-1];
                  end else begin
                     state_nxt  = IDLE;
                     load_max_c = 1'b1;
                  end
`else
                  state_nxt  = IDLE;
                  load_max_c = 1'b1;
`endif
               end else if (step_c && at_min_c) begin
                  state_nxt = CRUISE;
               end
            end
         end
`ifdef STEER_AUTOCENTER_EN
         RETURN: begin
            if (req_c) begin
               state_nxt  = ACCEL;
               load_max_c = 1'b1;
               dir_nxt    = req_dir_c;
            end else if (step_c) begin
               do_step_c = 1'b1;
               pos_nxt   = pos_step(pos_q, dir_q);
               if (pos_nxt == '0) begin
                  state_nxt  = IDLE;
                  load_max_c = 1'b1;
               end
            end
         end
`endif
         default: begin
            state_nxt  = IDLE;
            load_max_c = 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         left_q   <= 1'b0;
         right_q  <= 1'b0;
         state    <= IDLE;
         steer_q  <= 2'b00;
         dir_q    <= 1'b1;
         moving_q <= 1'b0;
      end else begin
         left_q   <= bus.left;
         right_q  <= bus.right;
         state    <= state_nxt;
         dir_q    <= dir_nxt;
         moving_q <= (state_nxt != IDLE);
         if (do_step_c)
            steer_q <= dir_q ? gray_next(steer_q) : gray_prev(steer_q);
      end
   end

`ifdef STEER_AUTOCENTER_EN
   always_ff @(posedge CLK or posedge reset) begin
      if (reset)
         pos_q <= '0;
      else
         pos_q <= pos_nxt;
   end
`endif

   assign bus.steer  = steer_q;
   assign bus.moving = moving_q;
   assign bus.dir    = dir_q;
   assign bus.period = period_w;

endmodule

// File: tb/tb_steer_quad_ctrl.sv
// Scoreboard bench for steer_quad_ctrl (MAX=8, MIN=2, STEP=2, ce high); STEER_AUTOCENTER_EN aware.
module tb_steer_quad_ctrl;

`ifdef STEER_AUTOCENTER_EN
   localparam bit AC = 1'b1;
`else
   localparam bit AC = 1'b0;
`endif

   typedef struct {
      int         at_edge;
      logic [1:0] steer;
      logic       dir;
      int         period;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   int   t0;
   exp_t exp_q[$];
   exp_t mon_e;
   logic [1:0] last_steer = 2'b00;

   steer_quad_ctrl_if bus ();

   steer_quad_ctrl #(
      .CLKDIV_MAX(8),
      .CLKDIV_MIN(2),
      .RAMP_STEP (2)
   ) dut (
      .CLK  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int e, input logic [1:0] s, input logic d, input int p);
      exp_t x;
      x.at_edge = e; x.steer = s; x.dir = d; x.period = p;
      exp_q.push_back(x);
   endtask

   task automatic wait_until(input int e);
      while (cyc < e) @(negedge clk);
   endtask

   // Caller is at a negedge; reset lands before the next active edge
   task automatic apply_reset();
      reset = 1'b1;
      bus.left = 1'b0;
      bus.right = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Monitor: every phase change must match the head of the scoreboard
   always @(negedge clk) begin
      if (reset) begin
         last_steer = bus.steer;
      end else if (bus.steer !== last_steer) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_step: steer=%b at edge %0d, nothing expected", bus.steer, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            check("step_edge", cyc, mon_e.at_edge);
            check("step_steer", int'(bus.steer), int'(mon_e.steer));
            check("step_dir", int'(bus.dir), int'(mon_e.dir));
            check("step_period", int'(bus.period), mon_e.period);
         end
         last_steer = bus.steer;
      end
   end

   initial begin
      bus.ce = 1'b1;
      bus.left = 1'b0;
      bus.right = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_steer", int'(bus.steer), 0);
      check("rst_moving", int'(bus.moving), 0);
      check("rst_dir", int'(bus.dir), 1);
      check("rst_period", int'(bus.period), 8);

      // Hold right: ramp 8,6,4 then cruise at 2; release lands on a step
      apply_reset();
      bus.right = 1'b1;
      t0 = cyc + 1;
      push(t0 + 9,  2'b01, 1'b1, 6);
      push(t0 + 15, 2'b11, 1'b1, 4);
      push(t0 + 19, 2'b10, 1'b1, 2);
      push(t0 + 21, 2'b00, 1'b1, 2);
      push(t0 + 23, 2'b01, 1'b1, 2);
      push(t0 + 25, 2'b11, 1'b1, 2);
      push(t0 + 27, 2'b10, AC ? 1'b0 : 1'b1, AC ? 2 : 8);
      wait_until(t0 + 20);
      check("hold_moving", int'(bus.moving), 1);
      wait_until(t0 + 25);
      bus.right = 1'b0;
      wait_until(t0 + 28);
`ifdef STEER_AUTOCENTER_EN
      apply_reset();
`endif
      check("release_moving", int'(bus.moving), 0);
      check("release_period", int'(bus.period), 8);
      check("release_steer", int'(bus.steer), AC ? 0 : 2);
      check("hold_pending", exp_q.size(), 0);

      // Both pressed: no request
      apply_reset();
      bus.left = 1'b1;
      bus.right = 1'b1;
      t0 = cyc + 1;
      wait_until(t0 + 50);
      check("both_moving", int'(bus.moving), 0);
      check("both_steer", int'(bus.steer), 0);
      check("both_dir", int'(bus.dir), 1);
      check("both_period", int'(bus.period), 8);
      bus.left = 1'b0;
      bus.right = 1'b0;

      // Reversal after 4 right steps, with a step due in the switch cycle
      apply_reset();
      bus.right = 1'b1;
      t0 = cyc + 1;
      push(t0 + 9,  2'b01, 1'b1, 6);
      push(t0 + 15, 2'b11, 1'b1, 4);
      push(t0 + 19, 2'b10, 1'b1, 2);
      push(t0 + 21, 2'b00, 1'b1, 2);
      wait_until(t0 + 21);
      bus.right = 1'b0;
      bus.left = 1'b1;
      wait_until(t0 + 23);
      check("rev_dir", int'(bus.dir), 0);
      check("rev_period", int'(bus.period), 8);
      check("rev_moving", int'(bus.moving), 1);
      check("rev_steer", int'(bus.steer), 0);
      push(t0 + 31, 2'b10, 1'b0, 6);
      wait_until(t0 + 32);
      check("rev_pending", exp_q.size(), 0);

      // Asynchronous reset mid-cruise, then re-press
      apply_reset();
      bus.right = 1'b1;
      t0 = cyc + 1;
      push(t0 + 9,  2'b01, 1'b1, 6);
      push(t0 + 15, 2'b11, 1'b1, 4);
      push(t0 + 19, 2'b10, 1'b1, 2);
      wait_until(t0 + 19);
      check("cruise_moving", int'(bus.moving), 1);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("async_steer", int'(bus.steer), 0);
      check("async_period", int'(bus.period), 8);
      check("async_moving", int'(bus.moving), 0);
      check("async_dir", int'(bus.dir), 1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      t0 = cyc + 1;
      push(t0 + 9, 2'b01, 1'b1, 6);
      wait_until(t0 + 10);
      check("repress_pending", exp_q.size(), 0);
      apply_reset();

`ifdef STEER_AUTOCENTER_EN
      // Five right steps, release, then five left steps back to centre
      bus.right = 1'b1;
      t0 = cyc + 1;
      push(t0 + 9,  2'b01, 1'b1, 6);
      push(t0 + 15, 2'b11, 1'b1, 4);
      push(t0 + 19, 2'b10, 1'b1, 2);
      push(t0 + 21, 2'b00, 1'b1, 2);
      push(t0 + 23, 2'b01, 1'b1, 2);
      wait_until(t0 + 22);
      bus.right = 1'b0;
      push(t0 + 26, 2'b00, 1'b0, 2);
      push(t0 + 28, 2'b10, 1'b0, 2);
      push(t0 + 30, 2'b11, 1'b0, 2);
      push(t0 + 32, 2'b01, 1'b0, 2);
      push(t0 + 34, 2'b00, 1'b0, 8);
      wait_until(t0 + 25);
      check("ret_moving", int'(bus.moving), 1);
      check("ret_dir", int'(bus.dir), 0);
      wait_until(t0 + 36);
      check("ret_idle_moving", int'(bus.moving), 0);
      check("ret_pending", exp_q.size(), 0);
`endif

      wait_until(cyc + 4);
      check("final_pending", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
